// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Collects results from NUM_FU functional units into one holding slot per FU
// and broadcasts one of them per cycle on the common data bus (CDB). The
// winner is picked round-robin, starting from the FU after the last winner.
// A handshake in cycle N with no competition reaches the CDB in cycle N+2.
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   fu_valid      : per-FU result valid
//   fu_rob_entry  : per-FU destination ROB tag, packed, FU i at [i*ROB_W +: ROB_W]
//   fu_value      : per-FU result value, packed, FU i at [i*DATA_W +: DATA_W]
//   fu_ready      : per-FU accept (combinational); FU holds result while not ready
//   flush         : synchronous flush, drops all held and presented results
//   cdb_valid     : broadcast valid (registered)
//   cdb_rob_entry : broadcast ROB tag (registered)
//   cdb_value     : broadcast value (registered)
//   cdb_src       : index of the FU owning the broadcast (registered)
//   pending       : holding-slot occupancy
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob_entry,
  input  logic [NUM_FU*DATA_W-1:0]   fu_value,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic                       flush,
  output logic                       cdb_valid,
  output logic [ROB_W-1:0]           cdb_rob_entry,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [2:0]                 cdb_src,
  output logic [NUM_FU-1:0]          pending
);

  localparam int IDX_W = 3;

  // (base + off) mod NUM_FU; both operands are below NUM_FU so one fold suffices
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int             off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_FU) begin
      sum = sum - NUM_FU;
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  logic [NUM_FU-1:0] hold_v_r;
  logic [ROB_W-1:0]  hold_tag_r [NUM_FU];
  logic [DATA_W-1:0] hold_val_r [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr_r;

  logic [NUM_FU-1:0] grant_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              grant_any_s;
  logic [NUM_FU-1:0] handshake_s;
  logic [IDX_W-1:0]  cand_s;

  // Round-robin pick: first occupied slot scanning upward from rr_ptr_r, wrapping
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    cand_s      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand_s = wrap_add(rr_ptr_r, k);
      if (!grant_any_s && hold_v_r[cand_s]) begin
        grant_any_s     = 1'b1;
        grant_idx_s     = cand_s;
        grant_s[cand_s] = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // A slot can accept when empty or when it is being drained this cycle
  always_comb begin
    fu_ready    = {NUM_FU{~flush}} & (~hold_v_r | grant_s);
    handshake_s = fu_valid & fu_ready;
    pending     = hold_v_r;
  end

  // Holding slots: load on handshake, clear on grant; a same-cycle handshake
  // on the granted FU wins so streaming results see no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_r <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        hold_tag_r[i] <= '0;
        hold_val_r[i] <= '0;
      end
    end else if (flush) begin
      hold_v_r <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (handshake_s[i]) begin
          hold_v_r[i]   <= 1'b1;
          hold_tag_r[i] <= fu_rob_entry[i*ROB_W +: ROB_W];
          hold_val_r[i] <= fu_value[i*DATA_W +: DATA_W];
        end else if (grant_s[i]) begin
          hold_v_r[i] <= 1'b0;
        end else begin
          hold_v_r[i] <= hold_v_r[i];
        end
      end
    end
  end

  // CDB output register and round-robin pointer; flush squashes the grant
  // but leaves the pointer where it was
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r      <= '0;
      cdb_valid     <= 1'b0;
      cdb_rob_entry <= '0;
      cdb_value     <= '0;
      cdb_src       <= 3'd0;
    end else if (flush) begin
      rr_ptr_r      <= rr_ptr_r;
      cdb_valid     <= 1'b0;
      cdb_rob_entry <= '0;
      cdb_value     <= '0;
      cdb_src       <= 3'd0;
    end else if (grant_any_s) begin
      rr_ptr_r      <= wrap_add(grant_idx_s, 1);
      cdb_valid     <= 1'b1;
      cdb_rob_entry <= hold_tag_r[grant_idx_s];
      cdb_value     <= hold_val_r[grant_idx_s];
      cdb_src       <= grant_idx_s;
    end else begin
      rr_ptr_r      <= rr_ptr_r;
      cdb_valid     <= 1'b0;
      cdb_rob_entry <= '0;
      cdb_value     <= '0;
      cdb_src       <= 3'd0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Randomized and directed stimulus for cdb_arbiter. A reference model tracks
// which FU results are waiting and the fairness pointer; at each clock edge it
// predicts the broadcast (if any) and queues it with the cycle it must appear
// in. A monitor on the falling edge compares the CDB, fu_ready and pending
// against the model.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int RW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      fu_valid;
  logic [N-1:0]      fu_ready;
  logic [N-1:0]      pending;
  logic [N*RW-1:0]   fu_rob_entry;
  logic [N*DW-1:0]   fu_value;
  logic              cdb_valid;
  logic [RW-1:0]     cdb_rob_entry;
  logic [DW-1:0]     cdb_value;
  logic [2:0]        cdb_src;

  cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .ROB_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .fu_valid(fu_valid), .fu_rob_entry(fu_rob_entry),
    .fu_value(fu_value), .fu_ready(fu_ready), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_rob_entry(cdb_rob_entry), .cdb_value(cdb_value), .cdb_src(cdb_src),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            src;
    logic [RW-1:0] tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  // reference model: waiting results per FU and the next FU to favour
  bit            m_v  [N];
  logic [RW-1:0] m_tag[N];
  logic [DW-1:0] m_val[N];
  bit            m_acc[N];
  int            m_rr;
  int            cyc;
  // bench-side FUs: result currently being offered
  bit            p_v  [N];
  logic [RW-1:0] p_tag[N];
  logic [DW-1:0] p_val[N];
  int            tag_ctr;
  bit            last_flush;
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // FU that should win: the waiting one closest at or after m_rr, cyclically
  function automatic int pick_grant();
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && ((i - m_rr + N) % N) < bestd) begin
        bestd = (i - m_rr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_step();
    int  g;
    bit  rdy[N];
    cyc++;
    for (int i = 0; i < N; i++) m_acc[i] = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_rr = 0;
      sb.delete();
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    end else begin
      g = pick_grant();
      for (int i = 0; i < N; i++) rdy[i] = !m_v[i] || (g == i);
      if (g >= 0) begin
        sb.push_back('{due: cyc, src: g, tag: m_tag[g], val: m_val[g]});
        m_v[g] = 1'b0;
        m_rr   = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && rdy[i]) begin
          m_v[i]   = 1'b1;
          m_tag[i] = fu_rob_entry[i*RW +: RW];
          m_val[i] = fu_value[i*DW +: DW];
          m_acc[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic mon_step();
    int         g;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    exp_t       e;
    g = pick_grant();
    for (int i = 0; i < N; i++) begin
      er[i] = !flush && (!m_v[i] || g == i);
      ev[i] = m_v[i];
    end
    check("fu_ready", 64'(fu_ready), 64'(er));
    check("pending", 64'(pending), 64'(ev));
    if (cdb_valid) begin
      if (sb.size() == 0) begin
        check("cdb_unexpected", 64'(cdb_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("cdb_cycle", 64'(cyc), 64'(e.due));
        check("cdb_src", 64'(cdb_src), 64'(e.src));
        check("cdb_tag", 64'(cdb_rob_entry), 64'(e.tag));
        check("cdb_value", 64'(cdb_value), 64'(e.val));
      end
    end else begin
      check("cdb_idle_zero", 64'({cdb_src, cdb_rob_entry, cdb_value}), 64'd0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("cdb_missing_src", 64'(cdb_valid), 64'd1);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) mon_step();
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fu_valid[i]             = p_v[i];
      fu_rob_entry[i*RW +: RW] = p_tag[i];
      fu_value[i*DW +: DW]     = p_val[i];
    end
  endtask

  // One cycle: retire accepted (or flushed) offers, add new ones, advance
  task automatic step(input logic [N-1:0] want, input bit fl);
    for (int i = 0; i < N; i++) begin
      if (p_v[i] && (m_acc[i] || last_flush)) p_v[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!p_v[i] && want[i]) begin
        p_v[i]   = 1'b1;
        p_tag[i] = tag_ctr[RW-1:0];
        p_val[i] = $urandom;
        tag_ctr++;
      end
    end
    last_flush = fl;
    flush      = fl;
    drive();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (8) step('0, 1'b0);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; tag_ctr = 0; last_flush = 1'b0; m_rr = 0;
    for (int i = 0; i < N; i++) begin
      p_v[i] = 1'b0; p_tag[i] = '0; p_val[i] = '0; m_v[i] = 1'b0; m_acc[i] = 1'b0;
    end
    rst_n = 1'b0; flush = 1'b0; fu_valid = '0; fu_rob_entry = '0; fu_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cdb", 64'({cdb_valid, cdb_src, cdb_rob_entry, cdb_value}), 64'd0);
    check("reset_pending", 64'(pending), 64'd0);
    check("reset_ready", 64'(fu_ready), 64'h1f);
    rst_n = 1'b1;

    // all five at once from rr_ptr=0: broadcast order 0..4
    step(5'h1f, 1'b0);
    drain();

    // single result from FU2
    p_v[2] = 1'b1; p_tag[2] = 4'd5; p_val[2] = 32'hDEADBEEF;
    step('0, 1'b0);
    drain();

    // fairness between FU0 and FU4
    repeat (20) step(5'h11, 1'b0);
    drain();

    // streaming from FU1, tags 0..9
    tag_ctr = 0;
    repeat (10) step(5'h02, 1'b0);
    drain();

    // three slots pending, then flush with fresh offers dropped
    step(5'h0e, 1'b0);
    step(5'h1f, 1'b1);
    drain();

    // randomized traffic with occasional flushes
    repeat (300) step(N'($urandom), ($urandom_range(0, 19) == 0));
    drain();

    // asynchronous reset mid-stream
    repeat (6) step(5'h1f, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_cdb", 64'({cdb_valid, cdb_src, cdb_rob_entry, cdb_value}), 64'd0);
    check("async_reset_pending", 64'(pending), 64'd0);
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_acc[i] = 1'b0; p_v[i] = 1'b0;
    end
    m_rr = 0; sb.delete(); last_flush = 1'b0; flush = 1'b0; fu_valid = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(5'h08, 1'b0);
    drain();
    repeat (50) step(N'($urandom), 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
